// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: four-master, one-slave Wishbone round-robin arbiter.
// The grant is registered and held for the whole of the owner's cycle. A
// watchdog aborts a strobe that the slave never acknowledges.
module wb_rr_arbiter #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int timeout   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  // master 0
  input  logic [adr_width-1:0]   m0_adr_i,
  input  logic [dat_width-1:0]   m0_dat_i,
  output logic [dat_width-1:0]   m0_dat_o,
  input  logic [dat_width/8-1:0] m0_sel_i,
  input  logic                   m0_we_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  // master 1
  input  logic [adr_width-1:0]   m1_adr_i,
  input  logic [dat_width-1:0]   m1_dat_i,
  output logic [dat_width-1:0]   m1_dat_o,
  input  logic [dat_width/8-1:0] m1_sel_i,
  input  logic                   m1_we_i,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  // master 2
  input  logic [adr_width-1:0]   m2_adr_i,
  input  logic [dat_width-1:0]   m2_dat_i,
  output logic [dat_width-1:0]   m2_dat_o,
  input  logic [dat_width/8-1:0] m2_sel_i,
  input  logic                   m2_we_i,
  input  logic                   m2_cyc_i,
  input  logic                   m2_stb_i,
  output logic                   m2_ack_o,
  output logic                   m2_err_o,
  // master 3
  input  logic [adr_width-1:0]   m3_adr_i,
  input  logic [dat_width-1:0]   m3_dat_i,
  output logic [dat_width-1:0]   m3_dat_o,
  input  logic [dat_width/8-1:0] m3_sel_i,
  input  logic                   m3_we_i,
  input  logic                   m3_cyc_i,
  input  logic                   m3_stb_i,
  output logic                   m3_ack_o,
  output logic                   m3_err_o,
  // slave
  output logic [adr_width-1:0]   s_adr_o,
  output logic [dat_width-1:0]   s_dat_o,
  input  logic [dat_width-1:0]   s_dat_i,
  output logic [dat_width/8-1:0] s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  // status
  output logic [1:0]             grant_o,
  output logic                   busy_o
);

  localparam int sel_width = dat_width / 8;
  // Wide enough to hold timeout-1 and to saturate; at least one bit.
  localparam int wdog_w = (timeout < 2) ? 1 : $clog2(timeout + 1);
  localparam bit wdog_en = (timeout > 0);
  localparam logic [wdog_w-1:0] wdog_lim = (timeout > 0) ? wdog_w'(timeout - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          last_q, last_d;
  logic [wdog_w-1:0]   wdog_q, wdog_d;

  logic [adr_width-1:0] m_adr [4];
  logic [dat_width-1:0] m_dat [4];
  logic [sel_width-1:0] m_sel [4];
  logic [3:0]           m_we, m_cyc, m_stb;
  logic [3:0]           ack_vec, err_vec;
  logic                 gnt_cyc, gnt_stb;

  // Gather the four master ports into indexable arrays.
  assign m_adr[0] = m0_adr_i;
  assign m_adr[1] = m1_adr_i;
  assign m_adr[2] = m2_adr_i;
  assign m_adr[3] = m3_adr_i;
  assign m_dat[0] = m0_dat_i;
  assign m_dat[1] = m1_dat_i;
  assign m_dat[2] = m2_dat_i;
  assign m_dat[3] = m3_dat_i;
  assign m_sel[0] = m0_sel_i;
  assign m_sel[1] = m1_sel_i;
  assign m_sel[2] = m2_sel_i;
  assign m_sel[3] = m3_sel_i;
  assign m_we     = {m3_we_i,  m2_we_i,  m1_we_i,  m0_we_i};
  assign m_cyc    = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign m_stb    = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};

  assign gnt_cyc = m_cyc[grant_q];
  assign gnt_stb = m_stb[grant_q];

  // Read data is broadcast; only the owner sees an ack qualifying it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;
  assign m3_dat_o = s_dat_i;
  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m2_ack_o = ack_vec[2];
  assign m3_ack_o = ack_vec[3];
  assign m0_err_o = err_vec[0];
  assign m1_err_o = err_vec[1];
  assign m2_err_o = err_vec[2];
  assign m3_err_o = err_vec[3];

  assign grant_o = grant_q;
  assign busy_o  = (state_q == GRANT);

  // First requester after 'last' in circular order; lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // State register: arbitration state, owner, round-robin pointer, watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold while the owner's cyc is up, abort on stall.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (|m_cyc) begin
          grant_d = rr_pick(m_cyc, last_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_cyc) begin
          last_d  = grant_q;
          wdog_d  = '0;
          state_d = IDLE;
        end else if (gnt_stb && !s_ack_i) begin
          if (wdog_en && (wdog_q == wdog_lim)) begin
            state_d = ABORT;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
          end
        end else begin
          wdog_d = '0;
        end
      end
      ABORT: begin
        last_d  = grant_q;
        wdog_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: route the owner to the slave in GRANT, flag the owner in ABORT.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    ack_vec = 4'b0000;
    err_vec = 4'b0000;
    case (state_q)
      GRANT: begin
        s_adr_o          = m_adr[grant_q];
        s_dat_o          = m_dat[grant_q];
        s_sel_o          = m_sel[grant_q];
        s_we_o           = m_we[grant_q];
        s_cyc_o          = gnt_cyc;
        s_stb_o          = gnt_cyc & gnt_stb;
        ack_vec[grant_q] = s_ack_i;
      end
      ABORT: err_vec[grant_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the round-robin arbiter.
module tb_wb_rr_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_adr [4];
  logic [31:0] m_wdat [4];
  logic [3:0]  m_sel [4];
  logic [3:0]  m_we, m_cyc, m_stb;
  logic [31:0] m_rdat [4];
  logic [3:0]  m_ack, m_err;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack;
  logic [1:0]  gnt;
  logic        busy;

  // second instance with the watchdog disabled, sharing all inputs
  logic [31:0] n_rdat [4];
  logic [3:0]  n_ack, n_err;
  logic [31:0] n_adr, n_wdat;
  logic [3:0]  n_sel;
  logic        n_we, n_cyc, n_stb;
  logic [1:0]  n_gnt;
  logic        n_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.adr_width(32), .dat_width(32), .timeout(TMO)) u_dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m_rdat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m_rdat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_wdat[2]), .m2_dat_o(m_rdat[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]),
    .m3_adr_i(m_adr[3]), .m3_dat_i(m_wdat[3]), .m3_dat_o(m_rdat[3]), .m3_sel_i(m_sel[3]),
    .m3_we_i(m_we[3]), .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]), .m3_ack_o(m_ack[3]), .m3_err_o(m_err[3]),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .grant_o(gnt), .busy_o(busy)
  );

  wb_rr_arbiter #(.adr_width(32), .dat_width(32), .timeout(0)) u_dut_nowd (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(n_rdat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(n_ack[0]), .m0_err_o(n_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(n_rdat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(n_ack[1]), .m1_err_o(n_err[1]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_wdat[2]), .m2_dat_o(n_rdat[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_ack_o(n_ack[2]), .m2_err_o(n_err[2]),
    .m3_adr_i(m_adr[3]), .m3_dat_i(m_wdat[3]), .m3_dat_o(n_rdat[3]), .m3_sel_i(m_sel[3]),
    .m3_we_i(m_we[3]), .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]), .m3_ack_o(n_ack[3]), .m3_err_o(n_err[3]),
    .s_adr_o(n_adr), .s_dat_o(n_wdat), .s_dat_i(s_rdat), .s_sel_o(n_sel), .s_we_o(n_we),
    .s_cyc_o(n_cyc), .s_stb_o(n_stb), .s_ack_i(s_ack), .grant_o(n_gnt), .busy_o(n_busy)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int md_owner;   // master holding the bus, -1 when nobody does
  int md_last;    // master served most recently
  int md_gnt;     // index presented on grant_o
  int md_stall;   // consecutive unacknowledged strobes
  bit md_abort;   // abort pulse pending for md_gnt

  logic [3:0] ex_ack, ex_err;
  logic       snap_cyc, snap_stb, snap_busy, snap_ncyc;
  logic [3:0] snap_ack, snap_err;
  logic [1:0] snap_gnt;
  logic [31:0] snap_rdat1;

  task automatic model_reset();
    md_owner = -1; md_last = 3; md_gnt = 0; md_stall = 0; md_abort = 1'b0;
  endtask

  task automatic model_step();
    if (md_abort) begin
      md_abort = 1'b0; md_last = md_gnt; md_owner = -1; md_stall = 0;
    end else if (md_owner < 0) begin
      md_stall = 0;
      for (int k = 1; k <= 4; k++) begin
        if (m_cyc[(md_last + k) % 4]) begin
          md_owner = (md_last + k) % 4;
          md_gnt = md_owner;
          break;
        end
      end
    end else if (!m_cyc[md_owner]) begin
      md_last = md_owner; md_owner = -1; md_stall = 0;
    end else if (m_stb[md_owner] && !s_ack) begin
      md_stall++;
      if (TMO > 0 && md_stall == TMO) begin
        md_abort = 1'b1; md_owner = -1; md_stall = 0;
      end
    end else begin
      md_stall = 0;
    end
  endtask

  // check all outputs mid-cycle against the model, keep a snapshot
  task automatic sample();
    logic       e_cyc, e_stb;
    logic [3:0] e_ack, e_err;
    @(negedge clk);
    e_cyc = 1'b0; e_stb = 1'b0; e_ack = 4'b0; e_err = 4'b0;
    if (md_owner >= 0) begin
      e_cyc = m_cyc[md_owner];
      e_stb = m_cyc[md_owner] & m_stb[md_owner];
      e_ack[md_owner] = s_ack;
      chk_eq("s_adr", s_adr, m_adr[md_owner]);
      chk_eq("s_dat", s_wdat, m_wdat[md_owner]);
      chk_eq("s_sel", s_sel, m_sel[md_owner]);
      chk_eq("s_we", s_we, m_we[md_owner]);
    end
    if (md_abort) e_err[md_gnt] = 1'b1;
    chk_eq("s_cyc", s_cyc, e_cyc);
    chk_eq("s_stb", s_stb, e_stb);
    chk_eq("ack", m_ack, e_ack);
    chk_eq("err", m_err, e_err);
    chk_eq("grant", gnt, md_gnt[1:0]);
    chk_eq("busy", busy, md_owner >= 0);
    for (int m = 0; m < 4; m++) chk_eq("dat_o", m_rdat[m], s_rdat);
    chk_eq("nowd_err", n_err, 4'b0);
    ex_ack = e_ack; ex_err = e_err;
    snap_cyc = s_cyc; snap_stb = s_stb; snap_busy = busy; snap_ncyc = n_cyc;
    snap_ack = m_ack; snap_err = m_err; snap_gnt = gnt; snap_rdat1 = m_rdat[1];
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic cyc1();
    sample();
    adv();
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 4; m++) begin
      m_adr[m] = 32'h0; m_wdat[m] = 32'h0; m_sel[m] = 4'h0;
    end
    m_we = 4'h0; m_cyc = 4'h0; m_stb = 4'h0;
    s_ack = 1'b0; s_rdat = 32'h0;
  endtask

  task automatic rand_fields(input int m);
    m_adr[m] = $urandom; m_wdat[m] = $urandom; m_sel[m] = 4'($urandom);
    m_we[m] = 1'($urandom);
  endtask

  // reset with requests and ack driven, which must not leak through
  task automatic do_reset();
    reset = 1'b1;
    m_cyc = 4'hf; m_stb = 4'hf; s_ack = 1'b1;
    #3;
    chk_eq("rst_cyc", s_cyc, 1'b0);
    chk_eq("rst_stb", s_stb, 1'b0);
    chk_eq("rst_ack", m_ack, 4'b0);
    chk_eq("rst_err", m_err, 4'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_grant", gnt, 2'd0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  int grants [$];
  logic [3:0] prev_ack;
  logic prev_busy;
  int acks3;
  bit act [4];
  int beats [4];

  initial begin
    idle_inputs();
    model_reset();
    do_reset();

    // single request from m1, slave acks on cycle 3
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; rand_fields(1);
    sample(); chk_eq("t1_c0_cyc", snap_cyc, 1'b0); adv();
    sample(); chk_eq("t1_c1_cyc", snap_cyc, 1'b1); chk_eq("t1_c1_gnt", snap_gnt, 2'd1); adv();
    cyc1();
    s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
    sample();
    chk_eq("t1_ack", snap_ack, 4'b0010);
    chk_eq("t1_rdat", snap_rdat1, 32'hDEADBEEF);
    chk_eq("t1_gnt", snap_gnt, 2'd1);
    adv();
    idle_inputs();
    cyc1(); cyc1();

    // contention m0 vs m2 straight after reset
    do_reset();
    m_cyc = 4'b0101; m_stb = 4'b0101;
    cyc1();
    s_ack = 1'b1;
    sample(); chk_eq("t2_first", snap_gnt, 2'd0); chk_eq("t2_ack0", snap_ack, 4'b0001); adv();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    cyc1();
    sample(); chk_eq("t2_gap", snap_busy, 1'b0); adv();
    sample(); chk_eq("t2_second", snap_gnt, 2'd2); chk_eq("t2_busy", snap_busy, 1'b1); adv();
    idle_inputs();
    cyc1(); cyc1();

    // fairness: all four keep requesting, one beat per grant
    do_reset();
    m_cyc = 4'hf; m_stb = 4'hf; s_ack = 1'b1;
    prev_ack = 4'b0; prev_busy = 1'b0;
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      m_cyc = ~prev_ack; m_stb = ~prev_ack;
      sample();
      if (snap_busy && !prev_busy) grants.push_back(int'(snap_gnt));
      prev_busy = snap_busy; prev_ack = snap_ack;
      adv();
    end
    chk_eq("fair_count", grants.size(), 5);
    for (int i = 0; i < grants.size(); i++) chk_eq("fair_order", grants[i], i % 4);
    idle_inputs();
    cyc1(); cyc1(); cyc1();

    // burst hold: m3 four beats while m0 waits
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1; rand_fields(3);
    cyc1();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1;
    acks3 = 0;
    for (int b = 0; b < 4; b++) begin
      rand_fields(3); s_rdat = $urandom;
      sample();
      if (snap_ack[3]) acks3++;
      chk_eq("burst_ack0", snap_ack[0], 1'b0);
      chk_eq("burst_gnt", snap_gnt, 2'd3);
      adv();
    end
    chk_eq("burst_acks", acks3, 4);
    m_cyc[3] = 1'b0; m_stb[3] = 1'b0; s_ack = 1'b0;
    cyc1();
    sample(); chk_eq("burst_gap", snap_busy, 1'b0); adv();
    sample(); chk_eq("burst_next", snap_gnt, 2'd0); chk_eq("burst_busy", snap_busy, 1'b1); adv();
    idle_inputs();
    cyc1(); cyc1();

    // watchdog: m2 strobes, slave never acks
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; rand_fields(2);
    cyc1();
    for (int i = 0; i < TMO; i++) begin
      sample();
      chk_eq("wd_stall_cyc", snap_cyc, 1'b1);
      chk_eq("wd_stall_err", snap_err, 4'b0);
      adv();
    end
    sample();
    chk_eq("wd_err", snap_err, 4'b0100);
    chk_eq("wd_abort_cyc", snap_cyc, 1'b0);
    chk_eq("wd_nowd_cyc", snap_ncyc, 1'b1);
    adv();
    idle_inputs();
    sample(); chk_eq("wd_err_pulse", snap_err, 4'b0); chk_eq("wd_idle", snap_busy, 1'b0); adv();
    cyc1(); cyc1();

    // random traffic against the model
    for (int m = 0; m < 4; m++) begin act[m] = 1'b0; beats[m] = 0; end
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 4; m++) begin
        if (act[m]) begin
          if (m_stb[m] && ex_ack[m]) beats[m]--;
          if (ex_err[m] || beats[m] <= 0) act[m] = 1'b0;
        end else if ($urandom_range(4) == 0) begin
          act[m] = 1'b1;
          beats[m] = 1 + $urandom_range(2);
        end
        m_cyc[m] = act[m];
        m_stb[m] = act[m] && ($urandom_range(3) != 0);
        rand_fields(m);
      end
      s_ack = 1'($urandom);
      s_rdat = $urandom;
      cyc1();
    end
    idle_inputs();
    cyc1(); cyc1(); cyc1();

    // reset in the middle of an m1 transfer
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; rand_fields(1);
    cyc1();
    sample(); chk_eq("mid_granted", snap_gnt, 2'd1); adv();
    s_ack = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_eq("mid_cyc", s_cyc, 1'b0);
    chk_eq("mid_stb", s_stb, 1'b0);
    chk_eq("mid_ack", m_ack, 4'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    s_ack = 1'b0;
    chk_eq("mid_rel_gnt", gnt, 2'd0);
    chk_eq("mid_rel_busy", busy, 1'b0);
    cyc1();
    sample(); chk_eq("mid_regrant", snap_gnt, 2'd1); chk_eq("mid_rebusy", snap_busy, 1'b1); adv();
    idle_inputs();
    cyc1(); cyc1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Four-master, one-slave Wishbone round-robin arbiter.
- Shares a single slave port (for example an SPI controller or block RAM) between the LM32 data bus, the external CPU/SRAM bridge and future DMA masters.
- Grants are registered and held for the whole of the winning master's cycle.
- A bus watchdog aborts any slave transfer that never acknowledges.

Parameters:
- adr_width, 32, address width of all master and slave address buses.
- dat_width, 32, data width; select width is dat_width/8.
- timeout, 255, stalled-strobe cycles before abort; 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous reset, active-high.
- mN_adr_i  input  adr_width  master N address (N=0..3).
- mN_dat_i  input  dat_width  master N write data.
- mN_dat_o  output  dat_width  master N read data (s_dat_i broadcast).
- mN_sel_i  input  dat_width/8  master N byte selects.
- mN_we_i  input  1  master N write enable.
- mN_cyc_i  input  1  master N cycle (the request).
- mN_stb_i  input  1  master N strobe.
- mN_ack_o  output  1  master N acknowledge.
- mN_err_o  output  1  master N error (watchdog abort).
- s_adr_o  output  adr_width  slave address.
- s_dat_o  output  dat_width  slave write data.
- s_dat_i  input  dat_width  slave read data.
- s_sel_o  output  dat_width/8  slave byte selects.
- s_we_o  output  1  slave write enable.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_ack_i  input  1  slave acknowledge.
- grant_o  output  2  index of the current owner.
- busy_o  output  1  high in GRANT state.

Behaviour:
- Reset values:
  - Registers: state=IDLE, grant=0, last=3, wdog=0.
  - Outputs: s_cyc_o=0, s_stb_o=0, every ack/err=0, busy_o=0, grant_o=0.
  - Reset asserted mid-transfer drops s_cyc_o/s_stb_o immediately. No ack reaches any master after reset.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - If any mN_cyc_i is high, grant the first requester scanning last+1, last+2, ... modulo 4. Go to GRANT next cycle.
  - Arbitration latency: request seen on edge k, s_cyc_o high from cycle k+1.
  - Slave signals are low in IDLE.
- GRANT:
  - Slave adr/dat/sel/we are muxed combinationally from the granted master.
  - s_cyc_o = granted cyc; s_stb_o = granted cyc & stb.
  - Granted master: ack_o = s_ack_i, combinational, no added latency. Non-granted masters: ack_o=0, err_o=0.
  - All mN_dat_o = s_dat_i.
  - Grant is held while the granted cyc is high, including multi-beat and back-to-back strobes.
  - Granted cyc low: last=grant, go to IDLE. This leaves a one-cycle gap before the next grant.
  - An ack in the same cycle as cyc deassertion is still forwarded.
- Watchdog:
  - wdog increments each cycle s_stb_o=1 and s_ack_i=0; it clears on s_ack_i or when s_stb_o=0.
  - When wdog==timeout-1 and no ack arrives, go to ABORT.
  - Counter saturates; it does not wrap.
- ABORT:
  - Lasts exactly one cycle. s_cyc_o=0, s_stb_o=0, granted err_o=1.
  - Then last=grant, wdog=0, go to IDLE.
  - If the master keeps cyc high, it re-requests and competes normally.
- Requests from other masters while a grant is held are ignored (ack stays 0) until IDLE.
- Simultaneous requests are resolved only by round-robin order; there is no fixed priority after reset except the initial last=3, which favours m0.

Test Plan:
- Single request: m1 cyc/stb high at cycle 0, slave acks at cycle 3 with s_dat_i=0xDEADBEEF → s_cyc_o high from cycle 1; m1_ack_o high at cycle 3 with m1_dat_o=0xDEADBEEF; grant_o=1; other acks 0.
- Contention: m0 and m2 request at the same cycle after reset → m0 granted first; after m0 drops cyc, one IDLE cycle, then m2 granted (grant_o 0 → 2).
- Fairness: all four masters request continuously, each one-beat → grant sequence 0,1,2,3,0; no master served twice before the others.
- Burst hold: m3 keeps cyc high for 4 strobes while m0 requests → m3 receives 4 acks and grant_o stays 3; m0 is granted only after m3 cyc falls.
- Watchdog: timeout=8, m2 strobes and slave never acks → after 8 stalled cycles m2_err_o pulses for 1 cycle, s_cyc_o=0 that cycle, state returns to IDLE; with timeout=0 no err ever fires.
- Reset mid-transfer: assert reset while m1 is granted with stb high → s_cyc_o/s_stb_o drop asynchronously; after release grant_o=0, busy_o=0, and a new m1 request is granted in 1 cycle.
